// File: rtl/hes_pkg.sv
// Shared types and sizing helpers for the multi-channel keystream scheduler.
package hes_pkg;
  localparam int NUM_CH_MAX = 8;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_MAX = ch_w(NUM_CH_MAX);

  typedef struct packed {
    logic [7:0] ctr;
    logic       in_msg;
  } ctx_t;

  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
    logic [7:0]          data;
    logic                sop;
    logic                eop;
  } stage_t;
endpackage

// File: rtl/hes_cipher_sched_if.sv
// Channel request, cipher-core and response signals of the keystream scheduler.
interface hes_cipher_sched_if #(parameter int NUM_CH = 4);
  import hes_pkg::*;
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]   req_valid;
  logic [NUM_CH-1:0]   req_ready;
  logic [NUM_CH*8-1:0] req_data;
  logic [NUM_CH-1:0]   req_sop;
  logic [NUM_CH-1:0]   req_eop;
  logic [NUM_CH*8-1:0] req_key;
  logic                cph_new_message;
  logic [7:0]          cph_key;
  logic                cph_valid_in;
  logic [7:0]          cph_data_in;
  logic [7:0]          cph_data_out;
  logic                cph_valid_out;
  logic                rsp_valid;
  logic [CH_W-1:0]     rsp_ch;
  logic [7:0]          rsp_data;
  logic                rsp_sop;
  logic                rsp_eop;
  logic                proto_err;

  modport slave (
    input  req_valid, req_data, req_sop, req_eop, req_key, cph_data_out, cph_valid_out,
    output req_ready, cph_new_message, cph_key, cph_valid_in, cph_data_in,
           rsp_valid, rsp_ch, rsp_data, rsp_sop, rsp_eop, proto_err
  );

  modport master (
    output req_valid, req_data, req_sop, req_eop, req_key, cph_data_out, cph_valid_out,
    input  req_ready, cph_new_message, cph_key, cph_valid_in, cph_data_in,
           rsp_valid, rsp_ch, rsp_data, rsp_sop, rsp_eop, proto_err
  );
endinterface

// File: rtl/hes_rr_arbiter.sv
// Round-robin arbiter; search starts after the last granted requester, optional hold on one channel.
module hes_rr_arbiter import hes_pkg::*; #(
  parameter  int N = 4,
  localparam int W = ch_w(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         lock_en,
  input  logic [W-1:0] lock_ch,
  output logic [N-1:0] grant,
  output logic [W-1:0] gnt_idx
);
  logic [W-1:0] ptr_q;
  logic         found;
  int           idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (lock_en) begin
      // Locked: only the owner may go; idle cycles are bubbles.
      if (req[lock_ch]) begin
        grant[lock_ch] = 1'b1;
        gnt_idx        = lock_ch;
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        idx = (int'(ptr_q) + i) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ptr_q <= W'(N - 1);
    else if (|grant)  ptr_q <= gnt_idx;
  end
endmodule

// File: rtl/hes_cipher_sched.sv
// Time-shares one keystream core among NUM_CH byte streams, reloading the core counter every cycle.
module hes_cipher_sched import hes_pkg::*; #(
  parameter int NUM_CH   = 4,
  parameter bit LOCK_MSG = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  hes_cipher_sched_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);

  ctx_t              ctx_q [NUM_CH];
  stage_t            s_q;
  logic              perr_q;
  logic              lock_q;
  logic [CH_W-1:0]   lock_ch_q;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic              xfer, sop, eop;
  logic [7:0]        data, key, ctr;

  hes_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid & {NUM_CH{reset_n}}),
    .lock_en (LOCK_MSG && lock_q),
    .lock_ch (lock_ch_q),
    .grant   (grant),
    .gnt_idx (gidx)
  );

  always_comb begin
    xfer = |grant;
    sop  = bus.req_sop[gidx];
    eop  = bus.req_eop[gidx];
    data = bus.req_data[int'(gidx)*8 +: 8];
    key  = bus.req_key[int'(gidx)*8 +: 8];
    ctr  = sop ? key : ctx_q[gidx].ctr;
  end

  // Core counter is reloaded every cycle, so idle cycles cannot disturb any channel's stream.
  assign bus.req_ready       = grant;
  assign bus.cph_new_message = reset_n;
  assign bus.cph_key         = xfer ? ctr : 8'h00;
  assign bus.cph_valid_in    = s_q.valid;
  assign bus.cph_data_in     = s_q.valid ? s_q.data : 8'h00;
  assign bus.rsp_valid       = s_q.valid & bus.cph_valid_out;
  assign bus.rsp_ch          = s_q.valid ? s_q.ch[CH_W-1:0] : '0;
  assign bus.rsp_data        = bus.rsp_valid ? bus.cph_data_out : 8'h00;
  assign bus.rsp_sop         = s_q.valid & s_q.sop;
  assign bus.rsp_eop         = s_q.valid & s_q.eop;
  assign bus.proto_err       = perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) ctx_q[i] <= '0;
    end else if (xfer) begin
      ctx_q[gidx].ctr    <= ctr + 8'd1;
      ctx_q[gidx].in_msg <= !eop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q       <= '0;
      perr_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      s_q.valid <= xfer;
      perr_q    <= xfer && !sop && !ctx_q[gidx].in_msg;
      if (xfer) begin
        s_q.ch   <= CH_W_MAX'(gidx);
        s_q.data <= data;
        s_q.sop  <= sop;
        s_q.eop  <= eop;
        if (eop) lock_q <= 1'b0;
        else if (sop) begin
          lock_q    <= 1'b1;
          lock_ch_q <= gidx;
        end
      end
    end
  end
endmodule

// File: tb/tb_hes_cipher_sched.sv
// Bench: two schedulers (byte round-robin and message lock) against a behavioural system model.
module tb_hes_cipher_sched;
  import hes_pkg::*;
  localparam int NCH = 4;
  localparam int CW  = ch_w(NCH);

  localparam logic [7:0] INV [256] = '{
    'h52,'h09,'h6a,'hd5,'h30,'h36,'ha5,'h38,'hbf,'h40,'ha3,'h9e,'h81,'hf3,'hd7,'hfb,
    'h7c,'he3,'h39,'h82,'h9b,'h2f,'hff,'h87,'h34,'h8e,'h43,'h44,'hc4,'hde,'he9,'hcb,
    'h54,'h7b,'h94,'h32,'ha6,'hc2,'h23,'h3d,'hee,'h4c,'h95,'h0b,'h42,'hfa,'hc3,'h4e,
    'h08,'h2e,'ha1,'h66,'h28,'hd9,'h24,'hb2,'h76,'h5b,'ha2,'h49,'h6d,'h8b,'hd1,'h25,
    'h72,'hf8,'hf6,'h64,'h86,'h68,'h98,'h16,'hd4,'ha4,'h5c,'hcc,'h5d,'h65,'hb6,'h92,
    'h6c,'h70,'h48,'h50,'hfd,'hed,'hb9,'hda,'h5e,'h15,'h46,'h57,'ha7,'h8d,'h9d,'h84,
    'h90,'hd8,'hab,'h00,'h8c,'hbc,'hd3,'h0a,'hf7,'he4,'h58,'h05,'hb8,'hb3,'h45,'h06,
    'hd0,'h2c,'h1e,'h8f,'hca,'h3f,'h0f,'h02,'hc1,'haf,'hbd,'h03,'h01,'h13,'h8a,'h6b,
    'h3a,'h91,'h11,'h41,'h4f,'h67,'hdc,'hea,'h97,'hf2,'hcf,'hce,'hf0,'hb4,'he6,'h73,
    'h96,'hac,'h74,'h22,'he7,'had,'h35,'h85,'he2,'hf9,'h37,'he8,'h1c,'h75,'hdf,'h6e,
    'h47,'hf1,'h1a,'h71,'h1d,'h29,'hc5,'h89,'h6f,'hb7,'h62,'h0e,'haa,'h18,'hbe,'h1b,
    'hfc,'h56,'h3e,'h4b,'hc6,'hd2,'h79,'h20,'h9a,'hdb,'hc0,'hfe,'h78,'hcd,'h5a,'hf4,
    'h1f,'hdd,'ha8,'h33,'h88,'h07,'hc7,'h31,'hb1,'h12,'h10,'h59,'h27,'h80,'hec,'h5f,
    'h60,'h51,'h7f,'ha9,'h19,'hb5,'h4a,'h0d,'h2d,'he5,'h7a,'h9f,'h93,'hc9,'h9c,'hef,
    'ha0,'he0,'h3b,'h4d,'hae,'h2a,'hf5,'hb0,'hc8,'heb,'hbb,'h3c,'h83,'h53,'h99,'h61,
    'h17,'h2b,'h04,'h7e,'hba,'h77,'hd6,'h26,'he1,'h69,'h14,'h63,'h55,'h21,'h0c,'h7d};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]   req_valid, req_sop, req_eop;
  logic [NCH*8-1:0] req_data, req_key;
  logic [NCH-1:0]   rdy [2];
  logic             rv [2], rs [2], re [2], pe [2];
  logic [7:0]       rd [2];
  logic [CW-1:0]    rc [2];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  for (genvar L = 0; L < 2; L++) begin : gi
    hes_cipher_sched_if #(.NUM_CH(NCH)) bus ();
    hes_cipher_sched #(.NUM_CH(NCH), .LOCK_MSG(L == 1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    assign bus.req_valid = req_valid;
    assign bus.req_data  = req_data;
    assign bus.req_sop   = req_sop;
    assign bus.req_eop   = req_eop;
    assign bus.req_key   = req_key;

    // Keystream core: counter reload/increment, output = data ^ invsbox[counter].
    logic [7:0] core_ctr = 8'h00;
    always @(posedge clk) core_ctr <= bus.cph_new_message ? bus.cph_key : core_ctr + 8'd1;
    assign bus.cph_data_out  = bus.cph_data_in ^ INV[core_ctr];
    assign bus.cph_valid_out = bus.cph_valid_in;

    assign rdy[L] = bus.req_ready;
    assign rv[L]  = bus.rsp_valid;
    assign rd[L]  = bus.rsp_data;
    assign rc[L]  = bus.rsp_ch;
    assign rs[L]  = bus.rsp_sop;
    assign re[L]  = bus.rsp_eop;
    assign pe[L]  = bus.proto_err;

    // Model state is the post-edge view; outputs are checked at every falling edge.
    initial begin
      int last, g, c, mlkch, pch;
      logic [7:0] mctr [NCH];
      bit minm [NCH];
      bit mlk, pv, psop, peop, perr;
      logic [7:0] pdat, pctr;
      string p;
      p = $sformatf("L%0d ", L);
      forever begin
        @(negedge clk);
        if (reset_n !== 1'b1) begin
          last = NCH - 1; mlk = 0; pv = 0; mlkch = 0;
          for (int i = 0; i < NCH; i++) begin mctr[i] = 8'h00; minm[i] = 0; end
          chk({p, "rst ready"},  64'(bus.req_ready), 0);
          chk({p, "rst newmsg"}, 64'(bus.cph_new_message), 0);
          chk({p, "rst key"},    64'(bus.cph_key), 0);
          chk({p, "rst vin"},    64'(bus.cph_valid_in), 0);
          chk({p, "rst rsp"},    64'({bus.rsp_valid, bus.rsp_data, bus.rsp_sop, bus.rsp_eop}), 0);
          chk({p, "rst perr"},   64'(bus.proto_err), 0);
        end else begin
          chk({p, "rsp_valid"}, 64'(bus.rsp_valid), 64'(pv));
          chk({p, "rsp_ch"},    64'(bus.rsp_ch), pv ? 64'(pch) : 0);
          chk({p, "rsp_data"},  64'(bus.rsp_data), pv ? 64'(pdat ^ INV[pctr]) : 0);
          chk({p, "rsp_sop"},   64'(bus.rsp_sop), 64'(pv && psop));
          chk({p, "rsp_eop"},   64'(bus.rsp_eop), 64'(pv && peop));
          chk({p, "proto_err"}, 64'(bus.proto_err), 64'(pv && perr));
          chk({p, "vin"},       64'(bus.cph_valid_in), 64'(pv));
          chk({p, "din"},       64'(bus.cph_data_in), pv ? 64'(pdat) : 0);
          g = -1;
          if (L == 1 && mlk) begin
            if (req_valid[mlkch]) g = mlkch;
          end else begin
            for (int i = 1; i <= NCH; i++) begin
              c = (last + i) % NCH;
              if (g < 0 && req_valid[c]) g = c;
            end
          end
          chk({p, "ready"}, 64'(bus.req_ready), (g >= 0) ? 64'(1 << g) : 0);
          chk({p, "newmsg"}, 64'(bus.cph_new_message), 1);
          pv = (g >= 0);
          if (pv) begin
            pch  = g;
            pdat = req_data[8*g +: 8];
            psop = req_sop[g];
            peop = req_eop[g];
            pctr = psop ? req_key[8*g +: 8] : mctr[g];
            perr = !psop && !minm[g];
            mctr[g] = pctr + 8'd1;
            minm[g] = !peop;
            last    = g;
            if (peop) mlk = 0;
            else if (psop) begin mlk = 1; mlkch = g; end
          end
          chk({p, "cph_key"}, 64'(bus.cph_key), pv ? 64'(pctr) : 0);
        end
      end
    end
  end

  typedef struct { logic [7:0] data, key; bit sop, eop; int gap; } ent_t;
  typedef struct { int ch; logic [7:0] data; bit sop, eop, err; int cyc; } rsp_t;
  typedef struct { int ch; int cyc; } xf_t;
  ent_t q [NCH][$];
  rsp_t rlog [$];
  xf_t  xlog [$];
  int   sel, cyc;

  task automatic add(input int c, input logic [7:0] d, input logic [7:0] k, input bit s, input bit e, input int gap);
    ent_t x;
    x.data = d; x.key = k; x.sop = s; x.eop = e; x.gap = gap;
    q[c].push_back(x);
  endtask

  task automatic present();
    ent_t h;
    for (int c = 0; c < NCH; c++) begin
      req_valid[c] = 0; req_sop[c] = 0; req_eop[c] = 0;
      req_data[8*c +: 8] = 8'h00; req_key[8*c +: 8] = 8'h00;
      if (q[c].size() > 0) begin
        h = q[c][0];
        if (h.gap > 0) begin
          h.gap--;
          q[c][0] = h;
        end else begin
          req_valid[c] = 1; req_sop[c] = h.sop; req_eop[c] = h.eop;
          req_data[8*c +: 8] = h.data; req_key[8*c +: 8] = h.key;
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] f;
    @(negedge clk);
    f = req_valid & rdy[sel];
    if (rv[sel]) rlog.push_back('{int'(rc[sel]), rd[sel], rs[sel], re[sel], pe[sel], cyc});
    for (int c = 0; c < NCH; c++) if (f[c]) xlog.push_back('{c, cyc});
    @(posedge clk); #1;
    cyc++;
    for (int c = 0; c < NCH; c++) if (f[c]) void'(q[c].pop_front());
    present();
  endtask

  function automatic bit idle();
    bit r = 1;
    for (int c = 0; c < NCH; c++) if (q[c].size() != 0) r = 0;
    return r;
  endfunction

  task automatic drain(input int lim, input string nm);
    int n = 0;
    while (!idle() && n < lim) begin step(); n++; end
    chk({nm, " drained"}, 64'(idle()), 1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    reset_n = 0;
    for (int c = 0; c < NCH; c++) q[c].delete();
    present();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    rlog.delete(); xlog.delete(); cyc = 0;
  endtask

  initial begin
    logic [7:0] ed [4];
    int ec [4];
    int n;
    reset_n = 0; sel = 0; cyc = 0;
    present();
    @(posedge clk); #1;

    // 1: contiguous bytes from key 0x00
    do_reset(); sel = 0;
    add(0, 8'h00, 8'h00, 1, 0, 0); add(0, 8'h00, 8'h00, 0, 0, 0); add(0, 8'h00, 8'h00, 0, 1, 0);
    present(); drain(50, "t1");
    ed = '{8'h52, 8'h09, 8'h6a, 8'h00};
    chk("t1 rsp count", 64'(rlog.size()), 3);
    if (rlog.size() == 3 && xlog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t1 data%0d", i), 64'(rlog[i].data), 64'(ed[i]));
        chk($sformatf("t1 latency%0d", i), 64'(rlog[i].cyc - xlog[i].cyc), 1);
      end
      chk("t1 sop/eop", 64'({rlog[0].sop, rlog[0].eop, rlog[1].sop, rlog[1].eop, rlog[2].sop, rlog[2].eop}), 64'b100001);
      chk("t1 contiguous", 64'(xlog[2].cyc - xlog[0].cyc), 2);
    end

    // 2: counter survives a five-cycle stall
    do_reset(); sel = 0;
    add(0, 8'h00, 8'h00, 1, 0, 0); add(0, 8'h00, 8'h00, 0, 1, 5);
    present(); drain(50, "t2");
    chk("t2 rsp count", 64'(rlog.size()), 2);
    if (rlog.size() == 2 && xlog.size() == 2) begin
      chk("t2 data1", 64'(rlog[1].data), 64'h09);
      chk("t2 gap", 64'(xlog[1].cyc - xlog[0].cyc), 6);
    end

    // 3: byte interleave of two channels
    do_reset(); sel = 0;
    add(0, 8'h00, 8'h00, 1, 0, 0); add(0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 8'h00, 8'h10, 1, 0, 0); add(1, 8'h00, 8'h00, 0, 1, 0);
    present(); drain(50, "t3");
    ed = '{8'h52, 8'h7c, 8'h09, 8'he3};
    ec = '{0, 1, 0, 1};
    chk("t3 rsp count", 64'(rlog.size()), 4);
    if (rlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3 ch%0d", i), 64'(rlog[i].ch), 64'(ec[i]));
        chk($sformatf("t3 data%0d", i), 64'(rlog[i].data), 64'(ed[i]));
      end

    // 4: counter wraps 0xff -> 0x00
    do_reset(); sel = 0;
    add(2, 8'h00, 8'hff, 1, 0, 0); add(2, 8'h01, 8'h00, 0, 1, 0);
    present(); drain(50, "t4");
    chk("t4 rsp count", 64'(rlog.size()), 2);
    if (rlog.size() == 2) begin
      chk("t4 data0", 64'(rlog[0].data), 64'h7d);
      chk("t4 data1", 64'(rlog[1].data), 64'h53);
      chk("t4 ch", 64'(rlog[1].ch), 2);
    end

    // 5: message lock holds ch0 off until ch1's eop
    do_reset(); sel = 1;
    add(1, 8'h00, 8'h20, 1, 0, 0); add(1, 8'h00, 8'h00, 0, 1, 2);
    add(0, 8'h33, 8'h40, 1, 1, 1);
    present(); drain(50, "t5");
    chk("t5 xfer count", 64'(xlog.size()), 3);
    if (xlog.size() == 3) begin
      chk("t5 order", 64'({xlog[0].ch[3:0], xlog[1].ch[3:0], xlog[2].ch[3:0]}), 64'h110);
      chk("t5 eop cycle", 64'(xlog[1].cyc), 3);
      chk("t5 ch0 next", 64'(xlog[2].cyc - xlog[1].cyc), 1);
    end

    // 6: reset drops the staged byte; then a stray non-sop byte raises proto_err
    do_reset(); sel = 0;
    add(0, 8'h11, 8'h40, 1, 0, 0); add(0, 8'h00, 8'h00, 0, 1, 3);
    present(); step();
    chk("t6 staged", 64'(xlog.size()), 1);
    reset_n = 0;
    #2;
    chk("t6 rsp_valid in reset", 64'(rv[0]), 0);
    do_reset();
    add(0, 8'h01, 8'h77, 0, 1, 0);
    present(); drain(50, "t6");
    chk("t6 rsp count", 64'(rlog.size()), 1);
    if (rlog.size() == 1) begin
      chk("t6 data", 64'(rlog[0].data), 64'h53);
      chk("t6 proto_err", 64'(rlog[0].err), 1);
    end
    chk("t6 err one cycle", 64'(pe[0]), 0);

    // Random traffic with gaps, restarts and stray non-sop starts, driven from each instance
    for (int s = 0; s < 2; s++) begin
      do_reset(); sel = s;
      for (int c = 0; c < NCH; c++)
        for (int m = 0; m < 6; m++) begin
          n = $urandom_range(1, 5);
          for (int b = 0; b < n; b++)
            add(c, 8'($urandom), 8'($urandom),
                (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0),
                b == n - 1,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
      present(); drain(3000, $sformatf("rand%0d", s));
      chk($sformatf("rand%0d activity", s), 64'(rlog.size() > 0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hes_cipher_sched.md
Name: hes_cipher_sched

Overview:
Multi-channel scheduler that time-shares one AES_cipher keystream core among NUM_CH byte-stream requesters.
- Keeps a per-channel 8-bit keystream counter context.
- Reloads the core counter every cycle through new_message/key, so channels can interleave byte-by-byte and stall arbitrarily without losing keystream alignment.
- Sits between the channel front-ends and the cipher core; all message traffic to the core passes through it.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
LOCK_MSG, 0, 1 = grant held by a channel from sop byte until its eop byte is accepted; 0 = byte-level round-robin

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CH  per-channel byte valid
req_ready  out  NUM_CH  per-channel accept (one-hot or zero)
req_data  in  NUM_CH*8  per-channel byte (channel c at [8c+7:8c])
req_sop  in  NUM_CH  byte is first of message
req_eop  in  NUM_CH  byte is last of message
req_key  in  NUM_CH*8  message key, sampled only on sop byte
cph_new_message  out  1  to core new_message
cph_key  out  8  to core key
cph_valid_in  out  1  to core valid_in
cph_data_in  out  8  to core data_in
cph_data_out  in  8  from core data_out
cph_valid_out  in  1  from core valid_out
rsp_valid  out  1  ciphered byte valid (no backpressure)
rsp_ch  out  $clog2(NUM_CH)  source channel
rsp_data  out  8  ciphered byte
rsp_sop  out  1  echo of sop
rsp_eop  out  1  echo of eop
proto_err  out  1  one-cycle pulse: non-sop byte accepted on a channel not in a message

Behaviour:
- Interface decided: clock clk; reset reset_n, asynchronous, active-low.
- Core model: at each edge the core counter loads cph_key if cph_new_message=1, else increments. Byte output = data_in XOR invsbox[counter].
- Arbitration:
  - Round-robin among req_valid bits, starting after the last granted channel.
  - After reset, channel 0 has highest priority.
  - At most one grant per cycle; req_ready[c] = grant[c], combinational from req_valid.
  - Transfer = req_valid & req_ready.
- LOCK_MSG=1: after a sop transfer on channel c (without eop), only c can be granted until c's eop transfer. Bubbles are allowed while c is not valid.
- Counter select on a transfer from channel c: ctr = req_sop[c] ? req_key[c] : ctx_ctr[c].
- Context update on the same edge: ctx_ctr[c] <= ctr+1, mod 256; 0xff wraps to 0x00. in_msg[c] <= !req_eop[c].
- Same cycle as a transfer: cph_new_message=1, cph_key=ctr. The core counter therefore equals ctr on the next cycle.
- No transfer: cph_new_message=1, cph_key=0x00.
- Stage register S captures {valid, ch, data, sop, eop} on the transfer edge. S.valid clears when there is no transfer.
- Cycle with S.valid=1: cph_valid_in=1, cph_data_in=S.data. rsp_valid = S.valid & cph_valid_out, rsp_data=cph_data_out, rsp_ch/sop/eop from S.
- When S.valid=0: cph_valid_in=0, cph_data_in=0; rsp outputs all 0.
- Latency: exactly 1 cycle, transfer edge to rsp_valid. Throughput: 1 byte/cycle aggregate.
- sop while in_msg[c]=1: restarts the message with the new key; no error.
- sop+eop on the same byte: single-byte message; in_msg stays 0.
- Non-sop transfer while in_msg[c]=0: byte is processed with ctx_ctr[c] and proto_err pulses in the next cycle, aligned with rsp_valid.
- Reset values: all ctx_ctr=0x00, in_msg=0, S.valid=0, RR pointer=NUM_CH-1, lock cleared.
- Reset outputs: req_ready=0, cph_new_message=0, cph_key=0, cph_valid_in=0, rsp_*=0, proto_err=0.
- Reset mid-message: the in-flight byte in S is dropped and all contexts are lost.

Decomposition:
- Package hes_pkg: NUM_CH_MAX=8 and CH_W localparam function; typedef ctx_t {logic [7:0] ctr; logic in_msg;}; typedef stage_t {valid, ch, data, sop, eop}.
- Sub-module hes_rr_arbiter: parameterised round-robin arbiter with req, lock_en, lock_ch, grant one-hot, pointer update on grant.

Test Plan:
1. ch0 key 0x00, bytes 0x00,0x00,0x00 contiguous -> rsp_data 0x52,0x09,0x6a on consecutive cycles, 1 cycle after each transfer; rsp_sop on first, rsp_eop on third.
2. ch0 key 0x00, byte 0x00, 5-cycle gap, byte 0x00 with eop -> second rsp_data 0x09, because the counter is preserved across the stall.
3. LOCK_MSG=0: ch0 key 0x00 and ch1 key 0x10 both continuously valid, 2 bytes 0x00 each -> rsp sequence ch0 0x52, ch1 0x7c, ch0 0x09, ch1 0xe3.
4. ch2 key 0xff, bytes 0x00,0x01 -> rsp 0x7d, 0x53 (counter wraps to 0x00).
5. LOCK_MSG=1: ch1 sop accepted, ch0 valid throughout, ch1 idles 2 cycles before its eop -> req_ready[0]=0 until the ch1 eop transfer, then ch0 is granted next cycle.
6. Assert reset_n low while S.valid=1 -> rsp_valid=0 immediately. After release, a non-sop byte 0x01 on ch0 -> rsp_data 0x53 and proto_err=1 for one cycle.
